alu_shift_operand_stage: RTL and testbench
==========================================

Name: alu_shift_operand_stage

Overview:
- Sequencing stage wrapped around the processor's combinational shift/rotate units (ror, rol, shr, shra, shl).
- Collects operand Rb, then shift amount Rc, from the shared 32-bit bus under a start/valid handshake.
- Drives the registered, range-reduced operands into the units, selects the result by opcode and latches it into the Z result register.
- Sits between the bus/control unit (upstream) and the shift/rotate datapath (downstream).

Parameters:
WIDTH, 32, datapath width. Must be a power of two.
AMT_BITS, 5, log2(WIDTH). Number of shift-amount bits kept from Rc.

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  reset, asynchronous, active-high.
start  in  1  request a new operation; sampled only in IDLE.
op  in  3  operation: 0=ROR, 1=ROL, 2=SHR, 3=SHRA, 4=SHL, 5-7 illegal; captured with start.
in_valid  in  1  BusMuxOut carries the next operand this cycle.
BusMuxOut  in  WIDTH  shared bus data.
Rb_out  out  WIDTH  registered operand to the shift/rotate units.
Rc_out  out  WIDTH  registered shift amount to the units: upper bits zero, low AMT_BITS = Rc mod WIDTH.
res_ror, res_rol, res_shr, res_shra, res_shl  in  WIDTH each  combinational unit results.
Z  out  WIDTH  result register.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse; Z valid and updated.
illegal  out  1  one-cycle pulse coincident with done when op was 5-7.

Behaviour:
- Reset (clr=1, asynchronous, any time including mid-operation):
  - state=IDLE; Rb_out, Rc_out, Z, stored op = 0; busy, done, illegal = 0.
  - A partial operation is discarded. No done is produced for it.
- States: IDLE, GET_B, GET_C, EXEC.
- IDLE:
  - start=1: capture op, go to GET_B.
  - in_valid is ignored in IDLE.
- GET_B:
  - in_valid=1: Rb_out<=BusMuxOut, go to GET_C.
  - Otherwise hold indefinitely (no timeout).
- GET_C:
  - in_valid=1: Rc_out<={zeros, BusMuxOut[AMT_BITS-1:0]}, go to EXEC.
  - Otherwise hold.
- EXEC (exactly one cycle, settle time for the units):
  - At its closing edge, Z<=mux(op) of res_* and done<=1, then go to IDLE.
  - Illegal op: Z<=Rb_out and illegal<=1.
- Latency: start at cycle 0 with in_valid high in cycles 1 and 2 gives EXEC in cycle 3 and done=1 in cycle 4. Minimum start-to-done is 4 cycles.
- done/illegal: registered, high for exactly one cycle, deasserted the following edge.
- start while busy: ignored and not queued. op changes while busy are ignored.
- Back-to-back operations: start may be asserted in the done cycle (state is IDLE). It is accepted, and Z holds the previous result until the next EXEC.
- Amount reduction: Rc=0 or any multiple of WIDTH gives Rc_out=0. Rc=33 gives Rc_out=1. Units never see amounts >= WIDTH.
- Holding: Rb_out, Rc_out and Z hold their values between operations. Z changes only at an EXEC closing edge or on clr.
- No arithmetic is performed in this block beyond truncation and selection. Widths are exact, with no sign extension of Rc.

Test Plan:
- Reset: assert clr mid-GET_C after Rb=0x12345678 loaded -> Rb_out=0, Z=0, busy=0 immediately (async); no done pulse thereafter.
- ROR basic: start op=0, Rb=0x0000000F, Rc=4, in_valid back-to-back, model ror -> Rc_out=4, done at cycle 4, Z=0xF0000000, illegal=0.
- Amount wrap: op=0, Rb=0x80000001, Rc=33 -> Rc_out=0x00000001, Z=0xC0000000. Repeat with Rc=32 -> Rc_out=0, Z=0x80000001.
- Stalls and ignored start: insert 3 idle cycles before each in_valid, pulse start during GET_B -> single done at cycle 10, second start not queued, busy high throughout.
- Illegal op: op=6, Rb=0xDEADBEEF, Rc=5 -> Z=0xDEADBEEF, done=1 and illegal=1 same cycle, both 0 next cycle.
- Back-to-back: start asserted in done cycle with op=4 (SHL), Rb=1, Rc=31 -> first Z held until second EXEC, then Z=0x80000000.

Source files
------------

// File: rtl/alu_shift_operand_stage_if.sv
// Upstream bus/control handshake of the shift operand stage: start/op request,
// operand transfers on the shared bus, and status plus the Z result back.
interface alu_shift_operand_stage_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             in_valid;
  logic [WIDTH-1:0] BusMuxOut;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] Z;

  modport master (
    output start, op, in_valid, BusMuxOut,
    input  busy, done, illegal, Z
  );

  modport slave (
    input  start, op, in_valid, BusMuxOut,
    output busy, done, illegal, Z
  );
endinterface

// File: rtl/alu_shift_operand_stage.sv
// Sequences Rb then Rc off the shared bus into the shift/rotate units, gives them
// one settle cycle, then latches the opcode-selected result into Z.
module alu_shift_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int AMT_BITS = 5
) (
  input  logic                    clk,
  input  logic                    clr,
  alu_shift_operand_stage_if.slave bus,
  output logic [WIDTH-1:0]        Rb_out,
  output logic [WIDTH-1:0]        Rc_out,
  input  logic [WIDTH-1:0]        res_ror,
  input  logic [WIDTH-1:0]        res_rol,
  input  logic [WIDTH-1:0]        res_shr,
  input  logic [WIDTH-1:0]        res_shra,
  input  logic [WIDTH-1:0]        res_shl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    GET_C = 2'd2,
    EXEC  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_rc;
  logic [WIDTH-1:0] r_z;
  logic             r_done;
  logic             r_illegal;
  logic             w_accept;
  logic             w_ld_b;
  logic             w_ld_c;
  logic             w_exec;
  logic [WIDTH-1:0] w_result;
  logic             w_illegal;

  // Keep only the low AMT_BITS so the units never see an amount >= WIDTH.
  function automatic logic [WIDTH-1:0] reduce_amt(input logic [WIDTH-1:0] v);
    reduce_amt = {{(WIDTH-AMT_BITS){1'b0}}, v[AMT_BITS-1:0]};
  endfunction

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ld_b   = 1'b0;
    w_ld_c   = 1'b0;
    w_exec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = GET_B;
        end
      end
      GET_B: begin
        if (bus.in_valid) begin
          w_ld_b = 1'b1;
          w_next = GET_C;
        end
      end
      GET_C: begin
        if (bus.in_valid) begin
          w_ld_c = 1'b1;
          w_next = EXEC;
        end
      end
      EXEC: begin
        w_exec = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Illegal opcodes pass Rb through unchanged.
  always_comb begin
    w_result  = r_rb;
    w_illegal = 1'b0;
    case (r_op)
      3'd0:    w_result = res_ror;
      3'd1:    w_result = res_rol;
      3'd2:    w_result = res_shr;
      3'd3:    w_result = res_shra;
      3'd4:    w_result = res_shl;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_op      <= 3'd0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_z       <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= w_exec;
      r_illegal <= w_exec & w_illegal;
      if (w_accept) r_op <= bus.op;
      if (w_ld_b)   r_rb <= bus.BusMuxOut;
      if (w_ld_c)   r_rc <= reduce_amt(bus.BusMuxOut);
      if (w_exec)   r_z  <= w_result;
    end
  end

  assign Rb_out      = r_rb;
  assign Rc_out      = r_rc;
  assign bus.Z       = r_z;
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_alu_shift_operand_stage.sv
// Directed bench for alu_shift_operand_stage: vector table plus hand-written
// reset, stall, and back-to-back sequences.
module tb_alu_shift_operand_stage;

  logic        clk;
  logic        clr;
  logic [31:0] Rb_out;
  logic [31:0] Rc_out;
  logic [31:0] res_ror, res_rol, res_shr, res_shra, res_shl;
  logic [5:0]  w_inv;

  int n_checks;
  int n_fail;

  alu_shift_operand_stage_if #(.WIDTH(32)) u_if ();

  alu_shift_operand_stage #(.WIDTH(32), .AMT_BITS(5)) dut (
    .clk      (clk),
    .clr      (clr),
    .bus      (u_if),
    .Rb_out   (Rb_out),
    .Rc_out   (Rc_out),
    .res_ror  (res_ror),
    .res_rol  (res_rol),
    .res_shr  (res_shr),
    .res_shra (res_shra),
    .res_shl  (res_shl)
  );

  // Stand-in for the downstream combinational shift/rotate units.
  assign w_inv    = 6'd32 - {1'b0, Rc_out[4:0]};
  assign res_ror  = (Rb_out >> Rc_out[4:0]) | (Rb_out << w_inv);
  assign res_rol  = (Rb_out << Rc_out[4:0]) | (Rb_out >> w_inv);
  assign res_shr  = Rb_out >> Rc_out[4:0];
  assign res_shra = $unsigned($signed(Rb_out) >>> Rc_out[4:0]);
  assign res_shl  = Rb_out << Rc_out[4:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rb;
    logic [31:0] rc;
    logic [31:0] exp_rc;
    logic [31:0] exp_z;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] z_prev;
    z_prev = u_if.Z;
    u_if.start = 1'b1;
    u_if.op    = v.op;
    tick();
    u_if.start = 1'b0;
    u_if.op    = 3'd0;
    check($sformatf("v%0d busy_getb", idx), {31'd0, u_if.busy}, 32'd1);
    u_if.in_valid  = 1'b1;
    u_if.BusMuxOut = v.rb;
    tick();
    check($sformatf("v%0d rb_out", idx), Rb_out, v.rb);
    u_if.BusMuxOut = v.rc;
    tick();
    u_if.in_valid = 1'b0;
    check($sformatf("v%0d rc_out", idx), Rc_out, v.exp_rc);
    check($sformatf("v%0d z_hold_exec", idx), u_if.Z, z_prev);
    check($sformatf("v%0d done_exec", idx), {31'd0, u_if.done}, 32'd0);
    tick();
    check($sformatf("v%0d done", idx), {31'd0, u_if.done}, 32'd1);
    check($sformatf("v%0d illegal", idx), {31'd0, u_if.illegal}, {31'd0, v.exp_ill});
    check($sformatf("v%0d z", idx), u_if.Z, v.exp_z);
    check($sformatf("v%0d busy_idle", idx), {31'd0, u_if.busy}, 32'd0);
    tick();
    check($sformatf("v%0d done_clr", idx), {31'd0, u_if.done}, 32'd0);
    check($sformatf("v%0d illegal_clr", idx), {31'd0, u_if.illegal}, 32'd0);
    check($sformatf("v%0d z_hold", idx), u_if.Z, v.exp_z);
  endtask

  initial begin
    vec_t v;
    int   ndone;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{3'd0, 32'h0000_000F, 32'd4,        32'd4,  32'hF000_0000, 1'b0};
    vecs[1] = '{3'd0, 32'h8000_0001, 32'd33,       32'd1,  32'hC000_0000, 1'b0};
    vecs[2] = '{3'd0, 32'h8000_0001, 32'd32,       32'd0,  32'h8000_0001, 1'b0};
    vecs[3] = '{3'd1, 32'h8000_0001, 32'd4,        32'd4,  32'h0000_0018, 1'b0};
    vecs[4] = '{3'd2, 32'hF000_0000, 32'd8,        32'd8,  32'h00F0_0000, 1'b0};
    vecs[5] = '{3'd3, 32'hF000_0000, 32'd8,        32'd8,  32'hFFF0_0000, 1'b0};
    vecs[6] = '{3'd4, 32'h0000_000F, 32'd28,       32'd28, 32'hF000_0000, 1'b0};
    vecs[7] = '{3'd6, 32'hDEAD_BEEF, 32'd5,        32'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[8] = '{3'd3, 32'h7000_0000, 32'hFFFF_FFC4, 32'd4, 32'h0700_0000, 1'b0};
    vecs[9] = '{3'd7, 32'h1234_5678, 32'd0,        32'd0,  32'h1234_5678, 1'b1};

    u_if.start     = 1'b0;
    u_if.op        = 3'd0;
    u_if.in_valid  = 1'b0;
    u_if.BusMuxOut = '0;
    clr = 1'b1;
    #12;
    check("rst_z", u_if.Z, 32'd0);
    check("rst_rb", Rb_out, 32'd0);
    check("rst_rc", Rc_out, 32'd0);
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_done", {31'd0, u_if.done}, 32'd0);
    clr = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // In IDLE a valid bus word must not load Rb.
    u_if.in_valid  = 1'b1;
    u_if.BusMuxOut = 32'hAAAA_5555;
    tick();
    u_if.in_valid = 1'b0;
    check("idle_ignore_rb", Rb_out, 32'h1234_5678);
    check("idle_ignore_busy", {31'd0, u_if.busy}, 32'd0);

    // Asynchronous clear in GET_C drops the partial operation.
    u_if.start = 1'b1;
    u_if.op    = 3'd0;
    tick();
    u_if.start     = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.BusMuxOut = 32'h1234_5678;
    tick();
    u_if.in_valid = 1'b0;
    check("clr_pre_rb", Rb_out, 32'h1234_5678);
    #2 clr = 1'b1;
    #1;
    check("clr_rb", Rb_out, 32'd0);
    check("clr_z", u_if.Z, 32'd0);
    check("clr_busy", {31'd0, u_if.busy}, 32'd0);
    tick();
    clr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      u_if.in_valid  = 1'b1;
      u_if.BusMuxOut = 32'd3 + c;
      tick();
      check($sformatf("clr_nodone_c%0d", c), {31'd0, u_if.done}, 32'd0);
      check($sformatf("clr_idle_c%0d", c), {31'd0, u_if.busy}, 32'd0);
    end
    u_if.in_valid = 1'b0;
    check("clr_after_rb", Rb_out, 32'd0);

    // Stalls of 3 cycles before each operand; a second start in GET_B is dropped.
    ndone = 0;
    u_if.start = 1'b1;
    u_if.op    = 3'd2;
    tick();
    for (int c = 1; c <= 13; c++) begin
      u_if.start     = (c == 2);
      u_if.op        = (c == 2) ? 3'd4 : 3'd2;
      u_if.in_valid  = (c == 4) || (c == 8);
      u_if.BusMuxOut = (c == 4) ? 32'h0000_0100 : 32'd4;
      tick();
      if (u_if.done) ndone++;
      check($sformatf("stall_done_c%0d", c + 1), {31'd0, u_if.done}, {31'd0, (c + 1) == 10});
      check($sformatf("stall_busy_c%0d", c + 1), {31'd0, u_if.busy}, {31'd0, (c + 1) <= 9});
    end
    u_if.start    = 1'b0;
    u_if.in_valid = 1'b0;
    check("stall_ndone", ndone, 32'd1);
    check("stall_z", u_if.Z, 32'h0000_0010);

    // Back-to-back: new start taken in the done cycle; Z holds until next EXEC.
    v = vecs[0];
    u_if.start = 1'b1;
    u_if.op    = v.op;
    tick();
    u_if.start     = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.BusMuxOut = v.rb;
    tick();
    u_if.BusMuxOut = v.rc;
    tick();
    u_if.in_valid = 1'b0;
    tick();
    check("b2b_first_done", {31'd0, u_if.done}, 32'd1);
    check("b2b_first_z", u_if.Z, 32'hF000_0000);
    u_if.start = 1'b1;
    u_if.op    = 3'd4;
    tick();
    u_if.start = 1'b0;
    check("b2b_accept_busy", {31'd0, u_if.busy}, 32'd1);
    check("b2b_z_hold_b", u_if.Z, 32'hF000_0000);
    u_if.in_valid  = 1'b1;
    u_if.BusMuxOut = 32'd1;
    tick();
    u_if.BusMuxOut = 32'd31;
    tick();
    u_if.in_valid = 1'b0;
    check("b2b_rc", Rc_out, 32'd31);
    check("b2b_z_hold_exec", u_if.Z, 32'hF000_0000);
    tick();
    check("b2b_done", {31'd0, u_if.done}, 32'd1);
    check("b2b_z", u_if.Z, 32'h8000_0000);
    check("b2b_illegal", {31'd0, u_if.illegal}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
